// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core definitions: bus widths, the "no producer" tag and
// the functional-unit index map used by the CDB arbiter and its clients.
package tomasulo_pkg;

  localparam int NUM_UNITS = 5;
  localparam int TAG_W     = 5;
  localparam int VAL_W     = 32;

  // A tag of all ones means "value already available / no producer".
  localparam logic [TAG_W-1:0] INVALID_TAG = 5'b11111;

  // Requester index of each functional unit on the CDB.
  localparam int UNIT_ADD   = 0;
  localparam int UNIT_LOGIC = 1;
  localparam int UNIT_MUL   = 2;
  localparam int UNIT_LOAD  = 3;
  localparam int UNIT_STORE = 4;

  typedef enum logic {
    CDB_IDLE = 1'b0,
    CDB_BUSY = 1'b1
  } cdb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: returns the first set bit of eligible when
// scanning from ptr upwards and wrapping at N. Purely combinational.
module rr_pick #(
  parameter int N  = 5,
  parameter int PW = 3
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] ptr,
  output logic          found,
  output logic [PW-1:0] winner
);

  logic [PW-1:0] idx_s;

  // Scan N positions starting at ptr; the first eligible one wins.
  always_comb begin
    found  = 1'b0;
    winner = {PW{1'b0}};
    idx_s  = {PW{1'b0}};
    for (int k = 0; k < N; k++) begin
      idx_s = PW'((int'(ptr) + k) % N);
      if (!found && eligible[idx_s]) begin
        found  = 1'b1;
        winner = idx_s;
      end else begin
        found  = found;
        winner = winner;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter for the Tomasulo core. Picks one requester per
// cycle in round-robin order and registers its tag/value onto the bus for
// a single cycle, returning a coincident one-hot grant.
// Optional statistics counters are built when CDB_ARB_STATS_EN is defined.
module cdb_arbiter
  import tomasulo_pkg::*;
#(
  parameter int NUM_REQ = NUM_UNITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       in_request,
  input  logic [NUM_REQ*TAG_W-1:0] in_tag,
  input  logic [NUM_REQ*VAL_W-1:0] in_val,
  input  logic                     in_hold,
`ifdef CDB_ARB_STATS_EN
  output logic [31:0]              out_busy_cycles,
  output logic [31:0]              out_conflict_cycles,
`endif
  output logic [NUM_REQ-1:0]       out_grant,
  output logic                     out_broadcast,
  output logic [TAG_W-1:0]         out_tag,
  output logic [VAL_W-1:0]         out_val
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   ptr_r;
  logic [NUM_REQ-1:0] eligible_s;
  logic               found_s;
  logic [PTR_W-1:0]   winner_s;
  logic [TAG_W-1:0]   win_tag_s;
  logic [VAL_W-1:0]   win_val_s;
  logic [NUM_REQ-1:0] grant_next_s;
  logic [PTR_W-1:0]   ptr_next_s;

  // A requester is eligible when it asks, carries a real tag, and was not
  // granted last cycle (it is dropping its request right now).
  always_comb begin
    eligible_s = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible_s[i] = in_request[i]
                    & (in_tag[i*TAG_W +: TAG_W] != INVALID_TAG)
                    & ~out_grant[i];
    end
  end

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PTR_W)
  ) u_rr_pick (
    .eligible (eligible_s),
    .ptr      (ptr_r),
    .found    (found_s),
    .winner   (winner_s)
  );

  // Winner payload, one-hot grant and the pointer just past the winner.
  always_comb begin
    win_tag_s    = in_tag[winner_s*TAG_W +: TAG_W];
    win_val_s    = in_val[winner_s*VAL_W +: VAL_W];
    grant_next_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_s;
    if (winner_s == PTR_W'(NUM_REQ - 1)) begin
      ptr_next_s = {PTR_W{1'b0}};
    end else begin
      ptr_next_s = winner_s + {{(PTR_W-1){1'b0}}, 1'b1};
    end
  end

  // Bus register: broadcast the winner for one cycle, otherwise idle with
  // an invalid tag while the last value is kept on the data lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_broadcast <= 1'b0;
      out_tag       <= INVALID_TAG;
      out_val       <= {VAL_W{1'b0}};
      out_grant     <= {NUM_REQ{1'b0}};
      ptr_r         <= {PTR_W{1'b0}};
    end else if (found_s && !in_hold) begin
      out_broadcast <= 1'b1;
      out_tag       <= win_tag_s;
      out_val       <= win_val_s;
      out_grant     <= grant_next_s;
      ptr_r         <= ptr_next_s;
    end else begin
      out_broadcast <= 1'b0;
      out_tag       <= INVALID_TAG;
      out_grant     <= {NUM_REQ{1'b0}};
    end
  end

`ifdef CDB_ARB_STATS_EN
  logic conflict_s;

  // Two or more eligible bits: clearing the lowest set bit leaves a one.
  always_comb begin
    conflict_s = ((eligible_s & (eligible_s - {{(NUM_REQ-1){1'b0}}, 1'b1}))
                  != {NUM_REQ{1'b0}});
  end

  // Saturating counters of busy bus cycles and contended cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_busy_cycles     <= 32'd0;
      out_conflict_cycles <= 32'd0;
    end else begin
      if (out_broadcast && (out_busy_cycles != 32'hFFFF_FFFF)) begin
        out_busy_cycles <= out_busy_cycles + 32'd1;
      end else begin
        out_busy_cycles <= out_busy_cycles;
      end
      if (conflict_s && (out_conflict_cycles != 32'hFFFF_FFFF)) begin
        out_conflict_cycles <= out_conflict_cycles + 32'd1;
      end else begin
        out_conflict_cycles <= out_conflict_cycles;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single grant, round-robin order,
// invalid-tag filtering, bus hold and (when enabled) the statistics.
module tb_cdb_arbiter;

  logic         clk;
  logic         rst;
  logic [4:0]   in_request;
  logic [24:0]  in_tag;
  logic [159:0] in_val;
  logic         in_hold;
  logic [4:0]   out_grant;
  logic         out_broadcast;
  logic [4:0]   out_tag;
  logic [31:0]  out_val;
`ifdef CDB_ARB_STATS_EN
  logic [31:0]  out_busy_cycles;
  logic [31:0]  out_conflict_cycles;
`endif

  int checks;
  int failures;

  cdb_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .in_request    (in_request),
    .in_tag        (in_tag),
    .in_val        (in_val),
    .in_hold       (in_hold),
`ifdef CDB_ARB_STATS_EN
    .out_busy_cycles     (out_busy_cycles),
    .out_conflict_cycles (out_conflict_cycles),
`endif
    .out_grant     (out_grant),
    .out_broadcast (out_broadcast),
    .out_tag       (out_tag),
    .out_val       (out_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [4:0] tag, input logic [31:0] val);
    in_request[idx]       = 1'b1;
    in_tag[idx*5 +: 5]    = tag;
    in_val[idx*32 +: 32]  = val;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_bc"},  {63'd0, out_broadcast}, 64'd0);
    check({tag, "_gnt"}, {59'd0, out_grant},     64'd0);
    check({tag, "_tag"}, {59'd0, out_tag},       64'd31);
  endtask

  task automatic check_grant(input string tag, input logic [4:0] gnt,
                             input logic [4:0] t, input logic [31:0] v);
    check({tag, "_bc"},  {63'd0, out_broadcast}, 64'd1);
    check({tag, "_gnt"}, {59'd0, out_grant},     {59'd0, gnt});
    check({tag, "_tag"}, {59'd0, out_tag},       {59'd0, t});
    check({tag, "_val"}, {32'd0, out_val},       {32'd0, v});
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    in_request = 5'd0;
    in_tag     = 25'd0;
    in_val     = 160'd0;
    in_hold    = 1'b0;

    // Reset values
    tick();
    tick();
    check_idle("rst");
    check("rst_val", {32'd0, out_val}, 64'd0);
    rst = 1'b0;

    // Single mul request, tag 7, value 16
    set_req(2, 5'd7, 32'h0000_0010);
    tick();
    check_grant("mul", 5'b00100, 5'd7, 32'h0000_0010);
    in_request = 5'd0;
    tick();
    check_idle("mul_after");
    check("mul_after_val", {32'd0, out_val}, 64'h10);

    // Reset asserted between edges during a broadcast (ptr is 3 here)
    set_req(2, 5'd7, 32'h0000_0010);
    tick();
    check("pre_rst_bc", {63'd0, out_broadcast}, 64'd1);
    #3;
    rst = 1'b1;
    #1;
    check_idle("async_rst");
    check("async_rst_val", {32'd0, out_val}, 64'd0);
    in_request = 5'd0;
    tick();
    rst = 1'b0;

    // All five requesting: order add, logic, mul, load, store, add
    for (int i = 0; i < 5; i++) set_req(i, 5'(i + 1), 32'(100 + i));
    for (int k = 0; k < 6; k++) begin
      tick();
      check_grant($sformatf("rr%0d", k), 5'(5'd1 << (k % 5)),
                  5'((k % 5) + 1), 32'(100 + (k % 5)));
    end
    in_request = 5'd0;
    tick();
    check("rr_end_bc", {63'd0, out_broadcast}, 64'd0);

    // ptr is 1. Add has INVALID_TAG, load tag 3: only load wins, ptr -> 4
    set_req(0, 5'b11111, 32'hAAAA_0000);
    set_req(3, 5'd3, 32'h0000_0333);
    tick();
    check_grant("inv_load", 5'b01000, 5'd3, 32'h0000_0333);
    in_request[3] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_idle($sformatf("inv_only%0d", k));
    end
    // ptr still 4: store beats add, then add follows
    set_req(0, 5'd9, 32'h0000_0009);
    set_req(4, 5'd12, 32'h0000_000C);
    tick();
    check_grant("ptr4_store", 5'b10000, 5'd12, 32'h0000_000C);
    in_request[4] = 1'b0;
    tick();
    check_grant("ptr0_add", 5'b00001, 5'd9, 32'h0000_0009);
    in_request = 5'd0;

    // Hold for 3 cycles with add and mul requesting, from ptr 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_hold = 1'b1;
    set_req(0, 5'd2, 32'h0000_0022);
    set_req(2, 5'd6, 32'h0000_0066);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_idle($sformatf("hold%0d", k));
    end
    in_hold = 1'b0;
    tick();
    check_grant("hold_add", 5'b00001, 5'd2, 32'h0000_0022);
    in_request[0] = 1'b0;
    tick();
    check_grant("hold_mul", 5'b00100, 5'd6, 32'h0000_0066);
    in_request[2] = 1'b0;
    tick();
    check_idle("hold_end");
    check("hold_end_val", {32'd0, out_val}, 64'h66);

`ifdef CDB_ARB_STATS_EN
    // Two continuous requesters for 10 cycles: bus busy every cycle, only
    // the first cycle has both eligible (afterwards one is always masked)
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("stat_rst_busy", {32'd0, out_busy_cycles}, 64'd0);
    check("stat_rst_conf", {32'd0, out_conflict_cycles}, 64'd0);
    set_req(0, 5'd1, 32'h1);
    set_req(2, 5'd3, 32'h3);
    for (int k = 0; k < 10; k++) tick();
    in_request = 5'd0;
    tick();
    check("stat_busy", {32'd0, out_busy_cycles}, 64'd10);
    check("stat_conf", {32'd0, out_conflict_cycles}, 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
